des_round_key_gen: RTL
======================

# des_round_key_gen

Sequential DES round-key generator directly downstream of the PC-1 parity-drop stage. It captures the 56-bit permuted key, performs the per-round C/D half rotations, and applies PC-2 to produce sixteen 48-bit round keys, one per accepted beat. A valid/ready handshake carries the keys to the round datapath.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a schedule; sampled only in IDLE.
- `subkey_in` in 56: PC-1 output. Index 0 is DES bit 1. C = [27:0], D = [55:28].
- `decrypt` in 1: present only with `KEYGEN_DECRYPT_EN`; sampled with `start`.
- `busy` out 1: high from the cycle after an accepted start until the last key is accepted.
- `key_valid` out 1: `round_key` and `round_idx` are valid.
- `key_ready` in 1: consumer accepts the key when `key_valid` and `key_ready` are both high.
- `round_key` out 48: `round_key[j] = CD[PC2[j]-1]`, where CD = {D,C}. PC2 = 14 17 11 24 1 5 3 28 15 6 21 10 23 19 12 4 26 8 16 7 27 20 13 2 41 52 31 37 47 55 30 40 51 45 33 48 44 49 39 56 34 53 46 42 50 36 29 32.
- `round_idx` out 4: round number 0..15 of the current key.
- `done` out 1: high while the round-15 key is presented; falls with its acceptance.

## Operation
- Clock: single clock `clk`. Reset: `rst` is asynchronous and active-high.
- State machine: IDLE and RUN.
- IDLE → RUN on `start`:
  - C and D registers load `rotl(subkey_in half, SHIFT[0])`.
  - `round_idx` loads 0.
  - `key_valid` goes to 1.
- Shift schedule: SHIFT = 1 1 2 2 2 2 2 2 1 2 2 2 2 2 2 1. The total over 16 rounds is 28.
- Rotation convention: DES "rotate left by n" on a 28-bit half h is `{h[n-1:0], h[27:n]}`, i.e. bit i takes h[(i+n) mod 28].
- RUN, on handshake with `round_idx` < 15:
  - C and D rotate by `SHIFT[round_idx+1]`.
  - `round_idx` increments.
- RUN, on handshake with `round_idx` = 15:
  - Go to IDLE.
  - `key_valid`, `busy` and `done` drop next cycle.
  - C and D hold.
- RUN without handshake: all state holds, so `round_key` is stable under backpressure.
- `round_key` is pure PC-2 wiring from the C/D registers. No extra register stage.
- `start` in RUN is ignored. `start` in the same cycle as the final handshake is also ignored; the earliest restart is the next cycle.
- `subkey_in` is don't-care except in the start cycle.
- Reset values: state IDLE; C = D = 0; `round_idx` = 0; `key_valid` = 0; `busy` = 0; `done` = 0; `round_key` = 0.
- Reset asserted mid-schedule aborts it immediately. No key is presented until a new `start`.

## Timing
- `start` sampled at edge T. The round-0 key is valid from T+1.
- With `key_ready` held high: keys appear on T+1 .. T+16, one per cycle. `done` is high on T+16. `key_valid` is 0 on T+17.
- Back-to-back schedules: 17-cycle period.
- Each cycle of `key_ready` low extends the schedule by one cycle.

## Configuration
- `KEYGEN_DECRYPT_EN` defined:
  - The `decrypt` port exists.
  - With `decrypt` = 1 at start: C and D load `subkey_in` unrotated, which equals K16's C/D.
  - Each handshake rotates right (`{h[27-n:0], h[27:28-n]}`) by `SHIFT[15-round_idx]`.
  - Output order is K16 .. K1, with `round_idx` still counting 0..15.
  - With `decrypt` = 0: encrypt behaviour as above.
- `KEYGEN_DECRYPT_EN` undefined: no `decrypt` port; encrypt order only.

## Test plan
- Bit-order convention for the vectors below: values are given in DES order, so `subkey_in[0]` and `round_key[0]` are the MSB of the hex.
- Encrypt known answer:
  - Stimulus: PC-1 of key 133457799BBCDFF1, i.e. C0 = 1111000011001100101010101111 and D0 = 0101010101100110011110001111. `key_ready` held at 1.
  - Required: `round_idx` 0 key = 1B02EFFC7072; `round_idx` 15 key = CB3D8B0E17F5 with `done` = 1; `busy` low on T+17.
- Degenerate keys: `subkey_in` = 0 → all 16 keys are 0. `subkey_in` all ones → all 16 keys are FFFFFFFFFFFF.
- Backpressure:
  - Stimulus: same key as the known-answer test; `key_ready` low for 3 cycles at `round_idx` 4, and toggled randomly elsewhere.
  - Required: `round_key` and `round_idx` stable while stalled; exactly 16 handshakes; the sequence matches the known-answer run.
- Control corner cases:
  - `start` pulsed at `round_idx` 7 → ignored; the sequence is unchanged.
  - `rst` asserted at `round_idx` 9 → all outputs 0 in the same cycle, IDLE afterwards.
  - A new `start` after reset → a full, correct schedule.
- Decrypt (`KEYGEN_DECRYPT_EN`):
  - Stimulus: same key as the known-answer test with `decrypt` = 1.
  - Required: first key = CB3D8B0E17F5; last key (with `done`) = 1B02EFFC7072.

Source files
------------

// File: rtl/des_round_key_gen.sv
// DES key schedule: captures the PC-1 output, rotates C/D per round, and presents PC-2 round keys.
// Optional macro KEYGEN_DECRYPT_EN adds a decrypt input that emits K16..K1 using right rotations.
module des_round_key_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [55:0] subkey_in,
`ifdef KEYGEN_DECRYPT_EN
  input  logic        decrypt,
`endif
  output logic        busy,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [47:0] round_key,
  output logic [3:0]  round_idx,
  output logic        done,
  output logic        o_dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  // One-based DES bit positions into CD = {D, C}
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      r_state;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [3:0]  r_idx;
  logic        r_key_valid;
  logic        r_busy;
  logic        r_done;
`ifdef KEYGEN_DECRYPT_EN
  logic        r_dec;
`endif

  logic        w_hs;
  logic        w_step_two;
  logic [27:0] w_load_c;
  logic [27:0] w_load_d;
  logic [27:0] w_step_c;
  logic [27:0] w_step_d;
  logic [55:0] w_cd;
  logic [47:0] w_round_key;

  // Rounds 1, 2, 9 and 16 (indices 0, 1, 8, 15) shift by one; all others by two.
  function automatic logic shift_is_two(input logic [3:0] i);
    return !(i == 4'd0 || i == 4'd1 || i == 4'd8 || i == 4'd15);
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] h, input logic two);
    return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
  endfunction

`ifdef KEYGEN_DECRYPT_EN
  function automatic logic [27:0] rotr(input logic [27:0] h, input logic two);
    return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
  endfunction
`endif

  // Valid/ready: a key transfers on a rising edge where key_valid && key_ready are both high;
  // while key_valid is high and key_ready is low every register holds, so round_key is stable.
  assign w_hs = r_key_valid && key_ready;

  always_comb begin
    w_load_c = rotl(subkey_in[27:0], 1'b0);
    w_load_d = rotl(subkey_in[55:28], 1'b0);
`ifdef KEYGEN_DECRYPT_EN
    if (decrypt) begin
      w_load_c = subkey_in[27:0];
      w_load_d = subkey_in[55:28];
    end
`endif
  end

  always_comb begin
    w_step_two = shift_is_two(r_idx + 4'd1);
    w_step_c   = rotl(r_c, w_step_two);
    w_step_d   = rotl(r_d, w_step_two);
`ifdef KEYGEN_DECRYPT_EN
    if (r_dec) begin
      w_step_two = shift_is_two(4'd15 - r_idx);
      w_step_c   = rotr(r_c, w_step_two);
      w_step_d   = rotr(r_d, w_step_two);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_c         <= '0;
      r_d         <= '0;
      r_idx       <= '0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef KEYGEN_DECRYPT_EN
      r_dec       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_c         <= w_load_c;
            r_d         <= w_load_d;
            r_idx       <= 4'd0;
            r_key_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
`ifdef KEYGEN_DECRYPT_EN
            r_dec       <= decrypt;
`endif
          end
        end
        S_RUN: begin
          if (w_hs) begin
            if (r_idx == 4'd15) begin
              // C/D hold so round_key stays at the last key until the next start
              r_state     <= S_IDLE;
              r_key_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b0;
            end else begin
              r_c    <= w_step_c;
              r_d    <= w_step_d;
              r_idx  <= r_idx + 4'd1;
              r_done <= (r_idx == 4'd14);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_cd = {r_d, r_c};

  for (genvar j = 0; j < 48; j++) begin : g_pc2
    assign w_round_key[j] = w_cd[PC2[j] - 1];
  end

  assign busy        = r_busy;
  assign key_valid   = r_key_valid;
  assign round_key   = w_round_key;
  assign round_idx   = r_idx;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule
